shift_arbiter: RTL

SHIFT_ARBITER -- requirements
Module: shift_arbiter

---
 rtl/shift_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/shift_arbiter.sv
// shift_arbiter
// Two-requester round-robin front end for one shared, purely combinational
// barrel shifter. One operation is in flight at a time:
//   IDLE -> accept a request (req<i>_ready pulses in the same cycle)
//   EXEC -> latched operands drive the shifter, the result is captured
//   RESP -> result is held on rsp_* until rsp_ready
//
// Ports
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   req<i>_valid/_ready       request handshake, i in {0,1}
//   req<i>_a/_b/_op           operand, shift amount, op (00 SLL, 01 SRL, 10 SRA, 11 illegal)
//   sh_a/sh_b/sh_extn         operand, amount and right-shift fill bit to the shifter
//   sh_lshift/sh_rshift       left / right results returned by the shifter
//   rsp_valid/rsp_ready       response handshake
//   rsp_data/rsp_id/rsp_err   result, originating requester, illegal-op flag
module shift_arbiter #(
  parameter int DATA_W = 32,
  localparam int SH_W = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [SH_W-1:0]   req0_b,
  input  logic [1:0]        req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [SH_W-1:0]   req1_b,
  input  logic [1:0]        req1_op,
  output logic [DATA_W-1:0] sh_a,
  output logic [SH_W-1:0]   sh_b,
  output logic              sh_extn,
  input  logic [DATA_W-1:0] sh_lshift,
  input  logic [DATA_W-1:0] sh_rshift,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_id,
  output logic              rsp_err
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  state_t              state;
  state_t              state_nxt;
  logic                last_grant;
  logic                grant_id;
  logic                accept;
  logic [DATA_W-1:0]   sel_a;
  logic [SH_W-1:0]     sel_b;
  logic [1:0]          sel_op;
  logic [1:0]          op_p0;
  logic                id_p0;

  function automatic logic [DATA_W-1:0] select_result(
    input logic [1:0]        op,
    input logic [DATA_W-1:0] lsh,
    input logic [DATA_W-1:0] rsh
  );
    case (op)
      OP_SLL:         return lsh;
      OP_SRL, OP_SRA: return rsh;
      default:        return '0;
    endcase
  endfunction

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    // Contention goes to whoever was not granted last; otherwise the lone requester.
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant;
    end else begin
      grant_id = req1_valid;
    end
    sel_a  = grant_id ? req1_a  : req0_a;
    sel_b  = grant_id ? req1_b  : req0_b;
    sel_op = grant_id ? req1_op : req0_op;
    case (state)
      IDLE: begin
        if (!rst && (req0_valid || req1_valid)) begin
          accept     = 1'b1;
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          state_nxt  = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state <= state_nxt;
      if (accept) begin
        last_grant <= grant_id;
      end
    end
  end

  // Stage 0: request capture; the shifter-facing registers double as the operand latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_a    <= '0;
      sh_b    <= '0;
      sh_extn <= 1'b0;
      op_p0   <= OP_SLL;
      id_p0   <= 1'b0;
    end else if (accept) begin
      sh_a    <= sel_a;
      sh_b    <= sel_b;
      sh_extn <= (sel_op == OP_SRA) && sel_a[DATA_W-1];
      op_p0   <= sel_op;
      id_p0   <= grant_id;
    end
  end

  // Stage 1: result capture at the end of EXEC, held through RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_data <= '0;
      rsp_id   <= 1'b0;
      rsp_err  <= 1'b0;
    end else if (state == EXEC) begin
      rsp_data <= select_result(op_p0, sh_lshift, sh_rshift);
      rsp_id   <= id_p0;
      rsp_err  <= (op_p0 == OP_ILL);
    end
  end

  assign rsp_valid = (state == RESP);

endmodule
